edge_delay_meter: RTL and testbench

Synthesizable measurement stage that sits directly downstream of the procedural-delay demonstration block. It consumes that block's stimulus input and one of its outputs. For each transition on the reference input, it counts the clock cycles until the observed output reaches the expected level (inverted or not). Each result is delivered through a valid/ready handshake, and the block keeps a running maximum and a measurement count.

---
 rtl/edge_delay_meter.sv | 137 +++++++++++++
 tb/tb_edge_delay_meter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/edge_delay_meter.sv
// Measures the clock-cycle delay between a reference input transition and the observed output
// reaching the expected level. Each result is delivered over a valid/ready handshake.
module edge_delay_meter #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ref_in,
  input  logic             dut_in,
  input  logic             invert,
  input  logic             enable,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_delay,
  output logic             meas_timeout,
  output logic             meas_overrun,
  output logic             busy,
  output logic [CNT_W-1:0] max_delay,
  output logic [15:0]      meas_count,
  output logic             edge_dropped
);

  typedef enum logic [1:0] {StIdle, StMeasure, StReport} state_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  state_e           state_q;
  logic             ref_meta_q, ref_s_q, ref_d_q;
  logic             dut_meta_q, dut_s_q;
  logic             target_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] meas_delay_q;
  logic             meas_timeout_q;
  logic             meas_overrun_q;
  logic [CNT_W-1:0] max_delay_q;
  logic [15:0]      meas_count_q;
  logic             edge_dropped_q;

  logic ref_edge;
  logic idle_target;
  logic dut_hit;

  always_comb begin
    ref_edge    = ref_s_q ^ ref_d_q;
    idle_target = ref_s_q ^ invert;
    dut_hit     = (dut_s_q == target_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      ref_meta_q     <= 1'b0;
      ref_s_q        <= 1'b0;
      ref_d_q        <= 1'b0;
      dut_meta_q     <= 1'b0;
      dut_s_q        <= 1'b0;
      target_q       <= 1'b0;
      cnt_q          <= '0;
      meas_delay_q   <= '0;
      meas_timeout_q <= 1'b0;
      meas_overrun_q <= 1'b0;
      max_delay_q    <= '0;
      meas_count_q   <= '0;
      edge_dropped_q <= 1'b0;
    end else begin
      // Equal two-flop latency on both paths keeps the measured offset unbiased.
      ref_meta_q <= ref_in;
      ref_s_q    <= ref_meta_q;
      ref_d_q    <= ref_s_q;
      dut_meta_q <= dut_in;
      dut_s_q    <= dut_meta_q;

      unique case (state_q)
        StIdle: begin
          if (ref_edge && enable) begin
            target_q <= idle_target;
            if (dut_s_q == idle_target) begin
              state_q        <= StReport;
              meas_delay_q   <= '0;
              meas_timeout_q <= 1'b0;
              meas_overrun_q <= 1'b0;
            end else begin
              state_q <= StMeasure;
              cnt_q   <= CntOne;
            end
          end
        end

        StMeasure: begin
          if (ref_edge) begin
            state_q        <= StReport;
            meas_delay_q   <= cnt_q;
            meas_timeout_q <= 1'b0;
            meas_overrun_q <= 1'b1;
          end else if (dut_hit) begin
            state_q        <= StReport;
            meas_delay_q   <= cnt_q;
            meas_timeout_q <= 1'b0;
            meas_overrun_q <= 1'b0;
            if (cnt_q > max_delay_q) max_delay_q <= cnt_q;
          end else if (cnt_q == TimeoutVal) begin
            state_q        <= StReport;
            meas_delay_q   <= TimeoutVal;
            meas_timeout_q <= 1'b1;
            meas_overrun_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StReport: begin
          if (ref_edge) edge_dropped_q <= 1'b1;
          if (meas_ready) begin
            state_q      <= StIdle;
            meas_count_q <= meas_count_q + 16'd1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    meas_valid   = (state_q == StReport);
    busy         = (state_q != StIdle);
    meas_delay   = meas_delay_q;
    meas_timeout = meas_timeout_q;
    meas_overrun = meas_overrun_q;
    max_delay    = max_delay_q;
    meas_count   = meas_count_q;
    edge_dropped = edge_dropped_q;
  end

endmodule

// File: tb/tb_edge_delay_meter.sv
// Directed bench for edge_delay_meter: stimulus pushes expected results into a scoreboard queue,
// a monitor pops and compares on each accepted result.
module tb_edge_delay_meter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ref_in = 1'b0;
  logic        dut_in = 1'b1;
  logic        invert = 1'b1;
  logic        enable = 1'b1;
  logic        meas_ready = 1'b1;
  logic        meas_valid;
  logic [7:0]  meas_delay;
  logic        meas_timeout;
  logic        meas_overrun;
  logic        busy;
  logic [7:0]  max_delay;
  logic [15:0] meas_count;
  logic        edge_dropped;

  typedef struct {
    logic [7:0] delay;
    logic       timeout;
    logic       overrun;
    logic [7:0] max;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  edge_delay_meter #(.CNT_W(8), .TIMEOUT(200)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ref_in       (ref_in),
    .dut_in       (dut_in),
    .invert       (invert),
    .enable       (enable),
    .meas_valid   (meas_valid),
    .meas_ready   (meas_ready),
    .meas_delay   (meas_delay),
    .meas_timeout (meas_timeout),
    .meas_overrun (meas_overrun),
    .busy         (busy),
    .max_delay    (max_delay),
    .meas_count   (meas_count),
    .edge_dropped (edge_dropped)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input logic [7:0] d, input logic t, input logic o,
                               input logic [7:0] m);
    exp_t e;
    e.delay = d; e.timeout = t; e.overrun = o; e.max = m;
    sb.push_back(e);
  endfunction

  // Monitor: samples just after the falling edge, well clear of the capturing rising edge.
  always begin
    @(negedge clock);
    #1;
    if (meas_valid && meas_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_delay", 32'(meas_delay), 32'(e.delay));
        check("sb_timeout", 32'(meas_timeout), 32'(e.timeout));
        check("sb_overrun", 32'(meas_overrun), 32'(e.overrun));
        check("sb_max_delay", 32'(max_delay), 32'(e.max));
      end
    end
  end

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy) return;
    end
    check({name, "_timeout_waiting"}, 32'd1, 32'd0);
    sb.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int vcount;

    // Reset values
    #3;
    check("rst_valid", 32'(meas_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_delay", 32'(meas_delay), 32'd0);
    check("rst_count", 32'(meas_count), 32'd0);
    check("rst_max", 32'(max_delay), 32'd0);
    check("rst_dropped", 32'(edge_dropped), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(5);

    // 1: invert=1, dut follows 3 cycles after ref
    push(8'd3, 1'b0, 1'b0, 8'd3);
    ref_in = 1'b1;
    idle(3);
    dut_in = 1'b0;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (meas_valid) vcount++;
    end
    check("t1_valid_cycles", 32'(vcount), 32'd1);
    check("t1_count", 32'(meas_count), 32'd1);
    check("t1_max", 32'(max_delay), 32'd3);

    // Edges with enable low are ignored
    enable = 1'b0;
    ref_in = 1'b0;
    idle(6);
    check("dis_busy", 32'(busy), 32'd0);
    ref_in = 1'b1;
    idle(6);
    dut_in = 1'b1;
    idle(4);
    check("dis_count", 32'(meas_count), 32'd1);

    // 2: both change on the same edge, invert=0
    enable = 1'b1;
    invert = 1'b0;
    push(8'd0, 1'b0, 1'b0, 8'd3);
    ref_in = 1'b0;
    dut_in = 1'b0;
    wait_done(20, "t2");
    check("t2_count", 32'(meas_count), 32'd2);

    // 3: dut stuck -> timeout, max unchanged
    push(8'd200, 1'b1, 1'b0, 8'd3);
    ref_in = 1'b1;
    wait_done(260, "t3");
    check("t3_count", 32'(meas_count), 32'd3);
    check("t3_max", 32'(max_delay), 32'd3);

    // 4: second ref edge 5 cycles later -> overrun
    invert = 1'b1;
    push(8'd5, 1'b0, 1'b1, 8'd3);
    ref_in = 1'b0;
    idle(5);
    ref_in = 1'b1;
    wait_done(30, "t4");
    idle(8);
    check("t4_no_restart", 32'(busy), 32'd0);
    check("t4_count", 32'(meas_count), 32'd4);
    check("t4_dropped", 32'(edge_dropped), 32'd0);

    // 5: consumer stalls 10 cycles, ref edge injected during REPORT
    meas_ready = 1'b0;
    push(8'd2, 1'b0, 1'b0, 8'd3);
    ref_in = 1'b0;
    idle(2);
    dut_in = 1'b1;
    for (int i = 0; i < 20 && !meas_valid; i++) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      check("t5_valid_stable", 32'(meas_valid), 32'd1);
      check("t5_delay_stable", 32'(meas_delay), 32'd2);
      if (i == 2) ref_in = 1'b1;
      @(negedge clock);
    end
    check("t5_dropped", 32'(edge_dropped), 32'd1);
    check("t5_count_held", 32'(meas_count), 32'd4);
    meas_ready = 1'b1;
    wait_done(10, "t5");
    check("t5_count", 32'(meas_count), 32'd5);

    // 6: asynchronous reset mid-measurement, then fresh 4-cycle measurement
    invert = 1'b0;
    ref_in = 1'b0;
    idle(4);
    check("t6_busy_pre", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(meas_valid), 32'd0);
    check("t6_rst_count", 32'(meas_count), 32'd0);
    check("t6_rst_max", 32'(max_delay), 32'd0);
    check("t6_rst_dropped", 32'(edge_dropped), 32'd0);
    check("t6_rst_delay", 32'(meas_delay), 32'd0);
    check("t6_rst_flags", 32'({meas_timeout, meas_overrun}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    dut_in = 1'b0;
    idle(5);
    push(8'd4, 1'b0, 1'b0, 8'd4);
    ref_in = 1'b1;
    idle(4);
    dut_in = 1'b1;
    wait_done(20, "t6");
    check("t6_count", 32'(meas_count), 32'd1);
    check("t6_max", 32'(max_delay), 32'd4);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
